// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit in the EX stage.
//
// Owns the architectural HI/LO registers. A mult/multu/div/divu issue
// captures its full 64-bit result at the issue edge and holds it as
// "pending". Busy then stays high for MULT_CYCLES or DIV_CYCLES cycles,
// and HI/LO are committed on the edge where Busy falls. mthi/mtlo write
// HI/LO one edge after issue. mfhi/mflo read HI/LO combinationally
// through MDUout_EX.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   Start      one-cycle issue strobe (ignored while Busy)
//   MDUOp      0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo,
//              7 mthi, 8 mtlo; any other value is treated as none
//   A_EX/B_EX  forwarded rs/rt operands
//   Busy       registered; high while a mult/div is in flight
//   HI/LO      architectural HI/LO registers
//   MDUout_EX  HI for mfhi, LO for mflo, 0 otherwise
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A_EX,
  input  logic [31:0] B_EX,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout_EX
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Signed 32x32 -> 64 product; the size casts sign-extend both operands.
  function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return p;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}. The divisor is forced to 1 when zero so
  // the operator never sees a zero divisor; the caller discards that result.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] d;
    d = (b == 32'd0) ? 32'd1 : b;
    return {a % d, a / d};
  endfunction

  // Signed divide done on magnitudes so 0x80000000 / -1 never overflows:
  // |0x80000000| is representable unsigned, and the quotient wraps back
  // to 0x80000000. Quotient truncates toward zero; remainder takes the
  // sign of the dividend.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] rq;
    logic [31:0] q;
    logic [31:0] r;
    mag_a = a[31] ? (32'd0 - 32'(a)) : 32'(a);
    mag_b = b[31] ? (32'd0 - 32'(b)) : 32'(b);
    rq    = div_unsigned(mag_a, mag_b);
    q     = (a[31] ^ b[31]) ? (32'd0 - rq[31:0]) : rq[31:0];
    r     = a[31] ? (32'd0 - rq[63:32]) : rq[63:32];
    return {r, q};
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  // Cleared for a divide by zero so completion leaves HI/LO untouched.
  logic             pend_ok_q, pend_ok_d;

  logic [63:0]      res_mult, res_multu, res_div, res_divu;

  always_comb begin
    res_mult  = mul_signed(A_EX, B_EX);
    res_multu = mul_unsigned(A_EX, B_EX);
    res_div   = div_signed(A_EX, B_EX);
    res_divu  = div_unsigned(A_EX, B_EX);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;

    if (state_q == S_IDLE) begin
      if (Start) begin
        case (MDUOp)
          OP_MULT, OP_MULTU: begin
            {pend_hi_d, pend_lo_d} = (MDUOp == OP_MULT) ? res_mult : res_multu;
            pend_ok_d = 1'b1;
            cnt_d     = MULT_LOAD;
            state_d   = S_RUN;
          end
          OP_DIV, OP_DIVU: begin
            {pend_hi_d, pend_lo_d} = (MDUOp == OP_DIV) ? res_div : res_divu;
            pend_ok_d = (B_EX != 32'd0);
            cnt_d     = DIV_LOAD;
            state_d   = S_RUN;
          end
          OP_MTHI: hi_d = A_EX;
          OP_MTLO: lo_d = A_EX;
          default: ;
        endcase
      end
    end else begin
      // Start is deliberately ignored here: a request while busy is a
      // hazard-unit violation and must not disturb the running operation.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = S_IDLE;
        if (pend_ok_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    case (MDUOp)
      OP_MFHI: MDUout_EX = hi_q;
      OP_MFLO: MDUout_EX = lo_q;
      default: MDUout_EX = 32'd0;
    endcase
  end

endmodule
